data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and dataMemory.
//  Holds 4-word (16-byte) lines. Refills a line by reading 4 consecutive words from dataMemory over 4 cycles.
//  Stalls the pipeline on read misses and on every write. Exposes access counters for hit-rate measurement.
// PARAMETERS
//  LINES   256  number of cache lines; power of 2; index = adr[3+log2(LINES):4]
//  ADDR_W  32   byte-address width; tag = adr[ADDR_W-1:4+log2(LINES)]
// PORTS
//  clk         in   1   clock, all state updates on posedge
//  reset       in   1   synchronous, active-high
//  cpu_adr     in   32  byte address; word aligned, adr[1:0] ignored
//  cpu_read    in   1   read request, held stable while stall=1
//  cpu_write   in   1   write request, held stable while stall=1
//  cpu_wdata   in   32  write data
//  cpu_rdata   out  32  read data, valid when cpu_read=1 and stall=0
//  stall       out  1   request not complete this cycle
//  mem_adr     out  32  dataMemory byte address (word aligned)
//  mem_read    out  1   dataMemory read enable
//  mem_write   out  1   dataMemory write enable
//  mem_wdata   out  32  dataMemory write data
//  mem_rdata   in   32  dataMemory read data, combinational from mem_adr
//  read_count  out  32  reads completed (stall=0 edges with cpu_read)
//  miss_count  out  32  line refills started
// BEHAVIOUR
//  Reset: state=IDLE, all valid bits=0, refill cnt=0, read_count=miss_count=0.
//   Outputs: stall=0, mem_read=0, mem_write=0, mem_adr=0, mem_wdata=0, cpu_rdata=0.
//   Tag/data arrays are not cleared. Reset in any state, incl. mid-refill, aborts the operation.
//  Hit = valid[index] && tag_ram[index]==tag. Word select = adr[3:2]. Words pass unchanged (memory is big-endian).
//  States: IDLE, REFILL, WRITE. stall, mem_* and cpu_rdata are combinational from state/regs/inputs.
//  IDLE, cpu_write=1 (priority over cpu_read): stall=1; next state WRITE.
//  IDLE, cpu_read=1, hit: stall=0; cpu_rdata=line word; read_count++ at edge.
//  IDLE, cpu_read=1, miss: stall=1; cnt<=0; miss_count++; next state REFILL.
//   The old line is discarded; write-through means no writeback.
//  IDLE, no request: stall=0; cpu_rdata=0; mem_* idle.
//  REFILL: stall=1; mem_read=1; mem_adr={tag,index,cnt,2'b00}.
//   Each edge writes mem_rdata into data[index][cnt]; cnt++.
//   At the cnt==3 edge: set tag_ram[index]=tag, valid[index]=1; next state IDLE.
//   The following IDLE cycle hits and completes the read.
//  WRITE: stall=0; mem_write=1; mem_adr={cpu_adr[31:2],2'b00}; mem_wdata=cpu_wdata.
//   On a hit, data[index][adr[3:2]]<=cpu_wdata at the same edge. A miss leaves the cache unchanged.
//   Next state IDLE; the write completes at this edge.
//  Read latency: hit 0 stall cycles. Miss: 5 stall cycles (1 detect + 4 refill), completes on the 6th cycle.
//  Write: 1 stall cycle, completes on the 2nd cycle.
//  mem_read and mem_write are never high together; neither is high in IDLE.
//  Counters wrap modulo 2^32. Hit rate = (read_count - miss_count) / read_count.
//  Back-to-back requests: a new request is sampled in the first IDLE cycle after completion.
// TESTING
//  T1 reset; mem[0x40..0x4C]=0x11223344,0x55667788,0x99AABBCC,0xDDEEFF00; read 0x40
//     -> stall=1 for 5 cycles; mem_read addresses 0x40,0x44,0x48,0x4C; then rdata 0x11223344, miss=1, read=1.
//  T2 after T1, read 0x44 -> stall=0 same cycle; rdata 0x55667788; mem_read=0; read=2, miss=1.
//  T3 write 0x48 data 0xDEADBEEF (hit) -> 1 stall cycle; mem_write=1 with adr 0x48;
//     then read 0x48 -> hit, rdata 0xDEADBEEF, no refill.
//  T4 read 0x1040 (index 4, tag 1) -> refill evicts line; then read 0x40 -> miss again; miss=3.
//  T5 write 0x2000 data 0x12345678 (miss) -> one mem_write, no mem_read;
//     then read 0x2000 -> miss, refill returns 0x12345678.
//  T6 reset during 2nd refill cycle -> next cycle IDLE, mem_read=0, counters 0; read 0x40 misses again.

Source files
------------

// File: rtl/data_cache_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_cache_if : CPU-side and dataMemory-side bus of the data cache     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface data_cache_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] cpu_adr;
   logic              cpu_read;
   logic              cpu_write;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              stall;
   logic [ADDR_W-1:0] mem_adr;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic [31:0]       read_count;
   logic [31:0]       miss_count;

   modport slave (
      input  cpu_adr, cpu_read, cpu_write, cpu_wdata, mem_rdata,
      output cpu_rdata, stall, mem_adr, mem_read, mem_write, mem_wdata,
             read_count, miss_count
   );

   modport master (
      output cpu_adr, cpu_read, cpu_write, cpu_wdata, mem_rdata,
      input  cpu_rdata, stall, mem_adr, mem_read, mem_write, mem_wdata,
             read_count, miss_count
   );
endinterface
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_cache : direct-mapped, write-through, no-write-allocate D-cache   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module data_cache #(
   parameter int LINES  = 256,
   parameter int ADDR_W = 32
) (
   input  wire              clk,
   input  wire              reset,
   data_cache_if.slave      bus
);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - 4 - IDX_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REFILL = 2'd1,
      S_WRITE  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_cnt;
   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [31:0]       r_data [LINES*4];
   logic [31:0]       r_read_count;
   logic [31:0]       r_miss_count;

   logic [IDX_W-1:0]  w_index;
   logic [TAG_W-1:0]  w_tag;
   logic [1:0]        w_word;
   logic              w_hit;
   logic              w_rd_req;
   logic              w_unused;

   assign w_index  = bus.cpu_adr[3+IDX_W:4];
   assign w_tag    = bus.cpu_adr[ADDR_W-1:4+IDX_W];
   assign w_word   = bus.cpu_adr[3:2];
   assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
   // Writes take priority over reads when both are requested.
   assign w_rd_req = bus.cpu_read && !bus.cpu_write;
   assign w_unused = &{1'b0, bus.cpu_adr[1:0]};

   assign bus.read_count = r_read_count;
   assign bus.miss_count = r_miss_count;

   always_comb begin
      w_next        = r_state;
      bus.stall     = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_adr   = '0;
      bus.mem_wdata = '0;
      bus.cpu_rdata = '0;
      case (r_state)
         S_IDLE: begin
            if (bus.cpu_write) begin
               bus.stall = 1'b1;
               w_next    = S_WRITE;
            end else if (bus.cpu_read) begin
               if (w_hit) begin
                  bus.cpu_rdata = r_data[{w_index, w_word}];
               end else begin
                  bus.stall = 1'b1;
                  w_next    = S_REFILL;
               end
            end
         end
         S_REFILL: begin
            bus.stall    = 1'b1;
            bus.mem_read = 1'b1;
            bus.mem_adr  = {w_tag, w_index, r_cnt, 2'b00};
            if (r_cnt == 2'd3) begin
               w_next = S_IDLE;
            end
         end
         S_WRITE: begin
            bus.mem_write = 1'b1;
            bus.mem_adr   = {bus.cpu_adr[ADDR_W-1:2], 2'b00};
            bus.mem_wdata = bus.cpu_wdata;
            w_next        = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= 2'd0;
         r_valid      <= '0;
         r_read_count <= 32'd0;
         r_miss_count <= 32'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_rd_req) begin
            if (w_hit) begin
               r_read_count <= r_read_count + 32'd1;
            end else begin
               r_cnt        <= 2'd0;
               r_miss_count <= r_miss_count + 32'd1;
            end
         end
         if (r_state == S_REFILL) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
               r_valid[w_index] <= 1'b1;
            end
         end
      end
   end

   // Tag and data arrays are never cleared; only the valid bits are.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == S_REFILL) begin
            r_data[{w_index, r_cnt}] <= bus.mem_rdata;
            if (r_cnt == 2'd3) begin
               r_tag[w_index] <= w_tag;
            end
         end else if (r_state == S_WRITE && w_hit) begin
            r_data[{w_index, w_word}] <= bus.cpu_wdata;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_cache : table-driven, scoreboarded bench for data_cache        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_data_cache;
   logic clk;
   logic reset;

   data_cache_if #(.ADDR_W(32)) bus ();

   data_cache #(.LINES(256), .ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // dataMemory model: 4096 words, combinational read.
   logic [31:0] mem [4096];
   assign bus.mem_rdata = mem[bus.mem_adr[13:2]];

   typedef struct {
      bit          is_wr;
      logic [31:0] adr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_stalls;
      logic [31:0] exp_reads;
      logic [31:0] exp_misses;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      int          stalls;
      bit          is_wr;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[10];
   int   n_cmp;
   int   n_bad;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic do_op(input vec_t v);
      exp_t        e;
      bit          done;
      int          stalls;
      int          nrd;
      int          nwr;
      bit          both;
      logic [31:0] got;
      logic [31:0] base;
      done   = 1'b0;
      stalls = 0;
      nrd    = 0;
      nwr    = 0;
      both   = 1'b0;
      got    = '0;
      base   = {v.adr[31:4], 4'h0};
      sb.push_back('{rdata: v.exp_rdata, stalls: v.exp_stalls, is_wr: v.is_wr});
      bus.cpu_adr   = v.adr;
      bus.cpu_wdata = v.wdata;
      bus.cpu_write = v.is_wr;
      bus.cpu_read  = !v.is_wr;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (bus.mem_read && bus.mem_write) both = 1'b1;
         if (bus.mem_read) begin
            chk($sformatf("refill_adr%0d", nrd), bus.mem_adr, base + 32'(nrd * 4));
            nrd++;
         end
         if (bus.mem_write) begin
            chk("wr_mem_adr", bus.mem_adr, {v.adr[31:2], 2'b00});
            chk("wr_mem_wdata", bus.mem_wdata, v.wdata);
            mem[bus.mem_adr[13:2]] = bus.mem_wdata;
            nwr++;
         end
         if (bus.stall) stalls++;
         else begin
            done = 1'b1;
            got  = bus.cpu_rdata;
         end
         @(posedge clk);
         @(negedge clk);
         if (done) break;
      end
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      chk("op_completed", {31'd0, done}, 32'd1);
      chk("rd_wr_exclusive", {31'd0, both}, 32'd0);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("stall_cycles", 32'(stalls), 32'(e.stalls));
         if (!e.is_wr) chk("cpu_rdata", got, e.rdata);
         chk("mem_read_cycles", 32'(nrd), (e.stalls == 5 && !e.is_wr) ? 32'd4 : 32'd0);
         chk("mem_write_cycles", 32'(nwr), e.is_wr ? 32'd1 : 32'd0);
      end
      #1;
      chk("read_count", bus.read_count, v.exp_reads);
      chk("miss_count", bus.miss_count, v.exp_misses);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
      chk({tag, "_mem_read"}, {31'd0, bus.mem_read}, 32'd0);
      chk({tag, "_mem_write"}, {31'd0, bus.mem_write}, 32'd0);
      chk({tag, "_mem_adr"}, bus.mem_adr, 32'd0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
      chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'd0);
      chk({tag, "_read_count"}, bus.read_count, 32'd0);
      chk({tag, "_miss_count"}, bus.miss_count, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | 32'(i * 4);
      mem[16] = 32'h1122_3344;
      mem[17] = 32'h5566_7788;
      mem[18] = 32'h99AA_BBCC;
      mem[19] = 32'hDDEE_FF00;

      //           wr    adr           wdata         exp_rdata     stalls reads  misses
      tbl[0] = '{1'b0, 32'h0000_0040, 32'h0,        32'h1122_3344, 5, 32'd1, 32'd1};
      tbl[1] = '{1'b0, 32'h0000_0044, 32'h0,        32'h5566_7788, 0, 32'd2, 32'd1};
      tbl[2] = '{1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 32'h0,        1, 32'd2, 32'd1};
      tbl[3] = '{1'b0, 32'h0000_0048, 32'h0,        32'hDEAD_BEEF, 0, 32'd3, 32'd1};
      tbl[4] = '{1'b0, 32'h0000_1040, 32'h0,        32'hA500_1040, 5, 32'd4, 32'd2};
      tbl[5] = '{1'b0, 32'h0000_0040, 32'h0,        32'h1122_3344, 5, 32'd5, 32'd3};
      tbl[6] = '{1'b0, 32'h0000_004C, 32'h0,        32'hDDEE_FF00, 0, 32'd6, 32'd3};
      tbl[7] = '{1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0,        1, 32'd6, 32'd3};
      tbl[8] = '{1'b0, 32'h0000_2000, 32'h0,        32'h1234_5678, 5, 32'd7, 32'd4};
      tbl[9] = '{1'b0, 32'h0000_0048, 32'h0,        32'hDEAD_BEEF, 0, 32'd8, 32'd4};

      bus.cpu_adr   = '0;
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_wdata = '0;
      reset         = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_idle("reset");

      for (int i = 0; i < 10; i++) do_op(tbl[i]);

      // Reset during the second refill cycle aborts the refill.
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset        = 1'b0;
      bus.cpu_adr  = 32'h0000_0040;
      bus.cpu_read = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("t6_mid_refill_mem_read", {31'd0, bus.mem_read}, 32'd1);
      chk("t6_mid_refill_adr", bus.mem_adr, 32'h0000_0044);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset        = 1'b0;
      bus.cpu_read = 1'b0;
      bus.cpu_adr  = '0;
      #1;
      chk_idle("t6_after_reset");
      @(negedge clk);
      do_op('{1'b0, 32'h0000_0040, 32'h0, 32'h1122_3344, 5, 32'd1, 32'd1});
      do_op('{1'b0, 32'h0000_0048, 32'h0, 32'hDEAD_BEEF, 0, 32'd2, 32'd1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
